// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with its own storage, fill count, programmable almost flags
// and sticky overflow/underflow error flags.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH         = 8,
  parameter int FIFO_ASIZE         = 4,
  parameter int ALMOST_FULL_LEVEL  = 2**FIFO_ASIZE - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic                  in_put,
  input  logic                  in_take,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_clear_errors,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_empty,
  output logic                  out_full,
  output logic                  out_almost_full,
  output logic                  out_almost_empty,
  output logic [FIFO_ASIZE:0]   out_count,
  output logic                  out_overflow,
  output logic                  out_underflow
);

  localparam int                DEPTH  = 2**FIFO_ASIZE;
  localparam logic [FIFO_ASIZE:0] C_DEPTH = (FIFO_ASIZE+1)'(DEPTH);
  localparam logic [FIFO_ASIZE:0] C_AF    = (FIFO_ASIZE+1)'(ALMOST_FULL_LEVEL);
  localparam logic [FIFO_ASIZE:0] C_AE    = (FIFO_ASIZE+1)'(ALMOST_EMPTY_LEVEL);
  localparam logic [FIFO_ASIZE:0] C_ZERO  = '0;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [FIFO_ASIZE:0]   r_wr_ptr;
  logic [FIFO_ASIZE:0]   r_rd_ptr;
  logic [FIFO_ASIZE:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_almost_full;
  logic                  r_almost_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_take_ok;
  logic                  w_put_ok;
  logic [FIFO_ASIZE:0]   w_count_next;
  logic [FIFO_ASIZE-1:0] w_wr_addr;
  logic [FIFO_ASIZE-1:0] w_rd_addr;

  // A take never falls through from a same-cycle put; a put at full needs a
  // concurrent accepted take to free a slot.
  assign w_take_ok = in_take && !r_empty;
  assign w_put_ok  = in_put && (!r_full || w_take_ok);
  assign w_wr_addr = r_wr_ptr[FIFO_ASIZE-1:0];
  assign w_rd_addr = r_rd_ptr[FIFO_ASIZE-1:0];

  always_comb begin
    w_count_next = r_count;
    if (w_put_ok && !w_take_ok) begin
      w_count_next = r_count + 1'b1;
    end else if (w_take_ok && !w_put_ok) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge in_clock) begin
    if (!in_reset && w_put_ok) begin
      r_mem[w_wr_addr] <= in_data;
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_data         <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_full  <= (C_ZERO >= C_AF);
      r_almost_empty <= (C_ZERO <= C_AE);
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_put_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_take_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_data   <= r_mem[w_rd_addr];
      end
      r_count        <= w_count_next;
      r_empty        <= (w_count_next == C_ZERO);
      r_full         <= (w_count_next == C_DEPTH);
      r_almost_full  <= (w_count_next >= C_AF);
      r_almost_empty <= (w_count_next <= C_AE);
      // A new error event wins over a same-cycle clear.
      if (in_put && !w_put_ok) begin
        r_overflow <= 1'b1;
      end else if (in_clear_errors) begin
        r_overflow <= 1'b0;
      end
      if (in_take && !w_take_ok) begin
        r_underflow <= 1'b1;
      end else if (in_clear_errors) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign out_data         = r_data;
  assign out_empty        = r_empty;
  assign out_full         = r_full;
  assign out_almost_full  = r_almost_full;
  assign out_almost_empty = r_almost_empty;
  assign out_count        = r_count;
  assign out_overflow     = r_overflow;
  assign out_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with DEPTH=4, almost-full 3, almost-empty 1.
module tb_sync_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       put;
  logic       take;
  logic [7:0] din;
  logic       clr;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic       afull;
  logic       aempty;
  logic [2:0] count;
  logic       ovf;
  logic       unf;

  int checks;
  int errors;

  sync_fifo_ctrl #(
    .DATA_WIDTH(8),
    .FIFO_ASIZE(2),
    .ALMOST_FULL_LEVEL(3),
    .ALMOST_EMPTY_LEVEL(1)
  ) dut (
    .in_clock(clk),
    .in_reset(rst),
    .in_put(put),
    .in_take(take),
    .in_data(din),
    .in_clear_errors(clr),
    .out_data(dout),
    .out_empty(empty),
    .out_full(full),
    .out_almost_full(afull),
    .out_almost_empty(aempty),
    .out_count(count),
    .out_overflow(ovf),
    .out_underflow(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, let the edge pass, then sample 1 time unit later.
  task automatic cycle(input logic p, input logic t, input logic [7:0] d,
                       input logic c, input logic r);
    put = p; take = t; din = d; clr = c; rst = r;
    @(posedge clk);
    #1;
    put = 1'b0; take = 1'b0; clr = 1'b0; rst = 1'b0;
    $display("txn rst=%0b put=%0b take=%0b din=%02h clr=%0b -> cnt=%0d dout=%02h e=%0b f=%0b ae=%0b af=%0b ovf=%0b unf=%0b",
             r, p, t, d, c, count, dout, empty, full, aempty, afull, ovf, unf);
  endtask

  task automatic test_reset;
    cycle(0, 0, 8'h00, 0, 1);
    cycle(0, 0, 8'h00, 0, 1);
    checks++;
    if ({count, empty, full, aempty, afull, ovf, unf, dout} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state cnt=%0d e=%0b f=%0b ae=%0b af=%0b ovf=%0b unf=%0b dout=%02h required cnt=0 e=1 f=0 ae=1 af=0 ovf=0 unf=0 dout=00",
               count, empty, full, aempty, afull, ovf, unf, dout);
    end
  endtask

  task automatic test_fill;
    logic [7:0] vals [4];
    logic [4:0] exp_flags [4];  // {empty, full, aempty, afull, ovf}
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_flags = '{5'b00100, 5'b00000, 5'b00010, 5'b01010};
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, vals[i], 0, 0);
      checks++;
      if (count !== 3'(i + 1) || {empty, full, aempty, afull, ovf} !== exp_flags[i]) begin
        errors++;
        $display("FAIL fill_%0d cnt=%0d flags=%05b required cnt=%0d flags=%05b",
                 i, count, {empty, full, aempty, afull, ovf}, i + 1, exp_flags[i]);
      end
    end
  endtask

  task automatic test_overflow_drain;
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    cycle(1, 0, 8'h55, 0, 0);
    checks++;
    if (ovf !== 1'b1 || count !== 3'd4 || full !== 1'b1 || dout !== 8'h00) begin
      errors++;
      $display("FAIL overflow ovf=%0b cnt=%0d f=%0b dout=%02h required ovf=1 cnt=4 f=1 dout=00",
               ovf, count, full, dout);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 8'h00, 0, 0);
      checks++;
      if (dout !== exp[i] || count !== 3'(3 - i) || full !== 1'b0) begin
        errors++;
        $display("FAIL drain_%0d dout=%02h cnt=%0d f=%0b required dout=%02h cnt=%0d f=0",
                 i, dout, count, full, exp[i], 3 - i);
      end
    end
    checks++;
    if (empty !== 1'b1 || aempty !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL drained_flags e=%0b ae=%0b ovf=%0b required e=1 ae=1 ovf=1", empty, aempty, ovf);
    end
    cycle(0, 0, 8'h00, 1, 0);
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL clear_overflow ovf=%0b required 0", ovf);
    end
  endtask

  task automatic test_underflow;
    cycle(1, 1, 8'hA0, 0, 0);
    checks++;
    if (unf !== 1'b1 || count !== 3'd1 || dout !== 8'h44 || empty !== 1'b0) begin
      errors++;
      $display("FAIL underflow_put_take unf=%0b cnt=%0d dout=%02h e=%0b required unf=1 cnt=1 dout=44 e=0",
               unf, count, dout, empty);
    end
    cycle(0, 1, 8'h00, 0, 0);
    checks++;
    if (dout !== 8'hA0 || count !== 3'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow_followup dout=%02h cnt=%0d e=%0b required dout=a0 cnt=0 e=1", dout, count, empty);
    end
    cycle(0, 0, 8'h00, 1, 0);
    checks++;
    if (unf !== 1'b0) begin
      errors++;
      $display("FAIL clear_underflow unf=%0b required 0", unf);
    end
  endtask

  task automatic test_full_put_take;
    logic [7:0] exp [4];
    exp = '{8'hB2, 8'hB3, 8'hB4, 8'h66};
    cycle(1, 0, 8'hB1, 0, 0);
    cycle(1, 0, 8'hB2, 0, 0);
    cycle(1, 0, 8'hB3, 0, 0);
    cycle(1, 0, 8'hB4, 0, 0);
    cycle(1, 1, 8'h66, 0, 0);
    checks++;
    if (count !== 3'd4 || dout !== 8'hB1 || ovf !== 1'b0 || full !== 1'b1 || unf !== 1'b0) begin
      errors++;
      $display("FAIL full_put_take cnt=%0d dout=%02h ovf=%0b f=%0b unf=%0b required cnt=4 dout=b1 ovf=0 f=1 unf=0",
               count, dout, ovf, full, unf);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 8'h00, 0, 0);
      checks++;
      if (dout !== exp[i] || count !== 3'(3 - i)) begin
        errors++;
        $display("FAIL full_drain_%0d dout=%02h cnt=%0d required dout=%02h cnt=%0d", i, dout, count, exp[i], 3 - i);
      end
    end
  endtask

  task automatic test_wrap;
    cycle(1, 0, 8'h00, 0, 0);
    cycle(1, 0, 8'h01, 0, 0);
    checks++;
    if (count !== 3'd2 || aempty !== 1'b0) begin
      errors++;
      $display("FAIL wrap_prime cnt=%0d ae=%0b required cnt=2 ae=0", count, aempty);
    end
    for (int i = 2; i < 10; i++) begin
      cycle(1, 1, 8'(i), 0, 0);
      checks++;
      if (dout !== 8'(i - 2) || count !== 3'd2) begin
        errors++;
        $display("FAIL wrap_pair_%0d dout=%02h cnt=%0d required dout=%02h cnt=2", i, dout, count, i - 2);
      end
    end
    for (int i = 8; i < 10; i++) begin
      cycle(0, 1, 8'h00, 0, 0);
      checks++;
      if (dout !== 8'(i) || count !== 3'(9 - i)) begin
        errors++;
        $display("FAIL wrap_tail_%0d dout=%02h cnt=%0d required dout=%02h cnt=%0d", i, dout, count, i, 9 - i);
      end
    end
    checks++;
    if (ovf !== 1'b0 || unf !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end ovf=%0b unf=%0b e=%0b required ovf=0 unf=0 e=1", ovf, unf, empty);
    end
  endtask

  task automatic test_reset_mid;
    cycle(0, 1, 8'h00, 0, 0);
    cycle(1, 0, 8'hC1, 0, 0);
    cycle(1, 0, 8'hC2, 0, 0);
    cycle(1, 0, 8'hC3, 0, 0);
    checks++;
    if (count !== 3'd3 || unf !== 1'b1 || afull !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset cnt=%0d unf=%0b af=%0b required cnt=3 unf=1 af=1", count, unf, afull);
    end
    cycle(1, 1, 8'hC4, 0, 1);
    checks++;
    if ({count, empty, full, aempty, afull, ovf, unf, dout} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset cnt=%0d e=%0b f=%0b ae=%0b af=%0b ovf=%0b unf=%0b dout=%02h required cnt=0 e=1 f=0 ae=1 af=0 ovf=0 unf=0 dout=00",
               count, empty, full, aempty, afull, ovf, unf, dout);
    end
    cycle(0, 1, 8'h00, 1, 0);
    checks++;
    if (unf !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL clear_vs_set unf=%0b cnt=%0d required unf=1 cnt=0", unf, count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    put = 1'b0; take = 1'b0; din = 8'h00; clr = 1'b0; rst = 1'b1;
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_full_put_take();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock FIFO: controller plus its own storage array, parametrised in data width and depth.
- Adds to the basic pointer controller: fill count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and defined simultaneous put/take at full and empty.
- Sits between a producer and a consumer in one clock domain; drop-in buffer for the module's datapaths.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- FIFO_ASIZE, 4, address width; DEPTH = 2**FIFO_ASIZE entries.
- ALMOST_FULL_LEVEL, 2**FIFO_ASIZE - 2, out_almost_full asserts when count >= this value. Legal range 1..DEPTH.
- ALMOST_EMPTY_LEVEL, 2, out_almost_empty asserts when count <= this value. Legal range 0..DEPTH-1.

Ports:
- in_clock  input  1  system clock; all state changes on the rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_put  input  1  write request for in_data this cycle.
- in_take  input  1  read request this cycle.
- in_data  input  DATA_WIDTH  write data, sampled on an accepted put.
- in_clear_errors  input  1  clears the sticky error flags.
- out_data  output  DATA_WIDTH  registered read data.
- out_empty  output  1  count == 0.
- out_full  output  1  count == DEPTH.
- out_almost_full  output  1  count >= ALMOST_FULL_LEVEL.
- out_almost_empty  output  1  count <= ALMOST_EMPTY_LEVEL.
- out_count  output  FIFO_ASIZE+1  current number of stored words, 0..DEPTH.
- out_overflow  output  1  sticky: a put was rejected.
- out_underflow  output  1  sticky: a take was rejected.

Behaviour:
- Reset, synchronous and active-high: read/write counters = 0, out_count = 0, out_empty = 1, out_full = 0, out_almost_empty = 1, out_almost_full = (ALMOST_FULL_LEVEL == 0, so 0), out_data = 0, out_overflow = 0, out_underflow = 0.
- Reset has priority over every other input. Reset mid-operation discards all contents; storage array contents are not cleared.
- Counters: read and write counters are FIFO_ASIZE+1 bits. The low FIFO_ASIZE bits address storage. Wrap-around is natural modulo 2**(FIFO_ASIZE+1).
- take_ok = in_take && !out_empty.
- put_ok = in_put && (!out_full || take_ok).
  - Put while full is accepted only when a take is accepted in the same cycle.
  - Take while empty is always rejected, even with a simultaneous put (no fall-through).
- On put_ok: mem[wr_addr] <= in_data; write counter +1.
- On take_ok: out_data <= mem[rd_addr]; read counter +1.
  - Latency: data is valid on out_data in the cycle after the accepting edge.
  - out_data holds its value when there is no accepted take.
- Count update: count_next = count + put_ok - take_ok. Simultaneous accepted put and take leaves the count unchanged and advances both pointers.
- All flags are registered and derived from count_next at the same edge, so they are consistent with out_count in every cycle.
- Errors:
  - in_put && !put_ok sets out_overflow.
  - in_take && !take_ok sets out_underflow.
  - Both are sticky until in_clear_errors or reset.
  - If in_clear_errors coincides with a new error event, the flag is set (the set wins).
- Rejected operations change no pointer, count or data.

Test Plan:
- DATA_WIDTH=8, FIFO_ASIZE=2 (DEPTH=4), AF=3, AE=1. After reset, put 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Required count 1,2,3,4.
  - almost_empty drops when count=2.
  - almost_full rises when count=3.
  - full=1 at count=4.
- From full, put 0x55 alone -> overflow=1, count stays 4. Then take x4 -> out_data 0x11,0x22,0x33,0x44, each one cycle after its take; empty=1 at the end.
- From empty, put 0xA0 and take together -> take rejected, underflow=1, count=1, out_data unchanged. Next cycle take -> out_data=0xA0, count=0.
- From full, put 0x66 and take together -> both accepted, count stays 4, out_data=oldest word, overflow stays 0.
- Wrap-around: 10 put/take pairs of 0x00..0x09, interleaved with count kept at 2 -> data emerges in order across pointer wrap.
- Reset asserted while count=3 -> next cycle count=0, empty=1, flags cleared. Then in_clear_errors together with a rejected take -> underflow remains 1.
